// File: rtl/decode_field_register.sv
//==============================================================================
// Module      : decode_field_register
// Description : Two-entry skid-buffered decode stage that splits RV32 words
//               into register/function fields and a raw 12-bit immediate.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module decode_field_register #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Flush,
    input  logic                   In_Valid,
    output logic                   In_Ready,
    input  logic [INSTR_WIDTH-1:0] In_Instruction,
    input  logic [PC_WIDTH-1:0]    In_PC,
    output logic                   Out_Valid,
    input  logic                   Out_Ready,
    output logic [PC_WIDTH-1:0]    Out_PC,
    output logic [6:0]             Out_Opcode,
    output logic [4:0]             Out_Rd,
    output logic [2:0]             Out_Funct3,
    output logic [4:0]             Out_Rs1,
    output logic [4:0]             Out_Rs2,
    output logic [6:0]             Out_Funct7,
    output logic [11:0]            Out_Imm12,
    output logic [2:0]             Out_Format,
    output logic                   Out_Illegal
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic [11:0] imm12;
        logic [2:0]  format;
        logic        illegal;
    } fields_t;

    function automatic fields_t decode(input logic [INSTR_WIDTH-1:0] instr);
        fields_t f;
        f         = '0;
        f.opcode  = instr[6:0];
        f.rd      = instr[11:7];
        f.funct3  = instr[14:12];
        f.rs1     = instr[19:15];
        f.rs2     = instr[24:20];
        f.funct7  = instr[31:25];
        f.format  = 3'd7;
        f.illegal = 1'b1;
        case (instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                f.imm12   = instr[31:20];
                f.format  = 3'd1;
                f.illegal = 1'b0;
            end
            7'b0100011: begin
                f.imm12   = {instr[31:25], instr[11:7]};
                f.format  = 3'd2;
                f.illegal = 1'b0;
            end
            // Branch offset bits imm[12:1]; imm[0] is always zero and dropped.
            7'b1100011: begin
                f.imm12   = {instr[31], instr[7], instr[30:25], instr[11:8]};
                f.format  = 3'd3;
                f.illegal = 1'b0;
            end
            7'b0110011: begin
                f.format  = 3'd0;
                f.illegal = 1'b0;
            end
            default: ;
        endcase
        return f;
    endfunction

    state_t                   state;
    state_t                   next_state;
    logic                     ready_q;
    logic                     accept;
    logic                     pop;
    logic                     load_main_in;
    logic                     load_main_skid;
    logic                     load_skid;
    logic [PC_WIDTH-1:0]      main_pc;
    fields_t                  main_f;
    logic [INSTR_WIDTH-1:0]   skid_instr;
    logic [PC_WIDTH-1:0]      skid_pc;

    assign In_Ready  = ready_q;
    assign Out_Valid = (state != EMPTY);
    assign accept    = In_Valid && ready_q;
    assign pop       = Out_Valid && Out_Ready;

    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (Flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        next_state   = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        next_state = TWO;
                        load_skid  = 1'b1;
                    end else if (pop) begin
                        next_state = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        next_state     = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: next_state = EMPTY;
            endcase
        end
    end

    // Ready is registered from the next state so Out_Ready never reaches In_Ready combinationally.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= EMPTY;
            ready_q    <= 1'b0;
            main_pc    <= '0;
            main_f     <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state != TWO);
            if (load_main_in) begin
                main_pc <= In_PC;
                main_f  <= decode(In_Instruction);
            end else if (load_main_skid) begin
                main_pc <= skid_pc;
                main_f  <= decode(skid_instr);
            end
            if (load_skid) begin
                skid_instr <= In_Instruction;
                skid_pc    <= In_PC;
            end
        end
    end

    assign Out_PC      = main_pc;
    assign Out_Opcode  = main_f.opcode;
    assign Out_Rd      = main_f.rd;
    assign Out_Funct3  = main_f.funct3;
    assign Out_Rs1     = main_f.rs1;
    assign Out_Rs2     = main_f.rs2;
    assign Out_Funct7  = main_f.funct7;
    assign Out_Imm12   = main_f.imm12;
    assign Out_Format  = main_f.format;
    assign Out_Illegal = main_f.illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_field_register.sv
//==============================================================================
// Module      : tb_decode_field_register
// Description : Self-checking bench for decode_field_register against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_decode_field_register;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Flush = 1'b0;
    logic        In_Valid = 1'b0;
    logic        In_Ready;
    logic [31:0] In_Instruction = '0;
    logic [31:0] In_PC = '0;
    logic        Out_Valid;
    logic        Out_Ready = 1'b0;
    logic [31:0] Out_PC;
    logic [6:0]  Out_Opcode;
    logic [4:0]  Out_Rd;
    logic [2:0]  Out_Funct3;
    logic [4:0]  Out_Rs1;
    logic [4:0]  Out_Rs2;
    logic [6:0]  Out_Funct7;
    logic [11:0] Out_Imm12;
    logic [2:0]  Out_Format;
    logic        Out_Illegal;

    decode_field_register #(.PC_WIDTH(32), .INSTR_WIDTH(32)) dut (
        .Clock(Clock), .Reset(Reset), .Flush(Flush),
        .In_Valid(In_Valid), .In_Ready(In_Ready),
        .In_Instruction(In_Instruction), .In_PC(In_PC),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_PC(Out_PC),
        .Out_Opcode(Out_Opcode), .Out_Rd(Out_Rd), .Out_Funct3(Out_Funct3),
        .Out_Rs1(Out_Rs1), .Out_Rs2(Out_Rs2), .Out_Funct7(Out_Funct7),
        .Out_Imm12(Out_Imm12), .Out_Format(Out_Format), .Out_Illegal(Out_Illegal)
    );

    always #5 Clock = ~Clock;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q_instr[$];
    logic [31:0] q_pc[$];
    bit          exp_ready = 1'b0;

    wire [79:0] dut_vec = {Out_PC, Out_Opcode, Out_Rd, Out_Funct3, Out_Rs1, Out_Rs2,
                           Out_Funct7, Out_Imm12, Out_Format, Out_Illegal};

    // Reference decode straight from the instruction-format tables.
    function automatic logic [47:0] model_decode(input logic [31:0] i);
        logic [11:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [12:0] boff;
        imm = 12'd0;
        fmt = 3'd7;
        ill = 1'b1;
        case (i[6:0])
            7'h03, 7'h13, 7'h67: begin imm = 12'(i >> 20); fmt = 3'd1; ill = 1'b0; end
            7'h23: begin imm = {i[31:25], i[11:7]}; fmt = 3'd2; ill = 1'b0; end
            7'h63: begin
                boff = {i[31], i[7], i[30:25], i[11:8], 1'b0};
                imm  = 12'(boff >> 1);
                fmt  = 3'd3;
                ill  = 1'b0;
            end
            7'h33: begin fmt = 3'd0; ill = 1'b0; end
            default: ;
        endcase
        return {i[6:0], i[11:7], i[14:12], i[19:15], i[24:20], i[31:25], imm, fmt, ill};
    endfunction

    function automatic logic [79:0] exp_vec();
        return {q_pc[0], model_decode(q_instr[0])};
    endfunction

    // Advance one clock and update the model from the inputs seen at that edge.
    task automatic tick();
        bit acc;
        bit pp;
        @(posedge Clock);
        if (Reset) begin
            q_instr.delete(); q_pc.delete(); exp_ready = 1'b0;
        end else if (Flush) begin
            q_instr.delete(); q_pc.delete(); exp_ready = 1'b1;
        end else begin
            acc = In_Valid && exp_ready;
            pp  = (q_instr.size() > 0) && Out_Ready;
            if (pp) begin void'(q_instr.pop_front()); void'(q_pc.pop_front()); end
            if (acc) begin q_instr.push_back(In_Instruction); q_pc.push_back(In_PC); end
            exp_ready = (q_instr.size() < 2);
        end
        #1;
    endtask

    task automatic fill_two(input logic [31:0] pc_base);
        Out_Ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            In_Valid = 1'b1; In_Instruction = 32'h00000013 | (32'(k) << 7); In_PC = pc_base + 32'(4 * k);
            tick();
        end
        In_Valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 Reset = 1'b1;
        #1;
        checks++;
        if (Out_Valid !== 1'b0 || In_Ready !== 1'b0 || dut_vec !== 80'd0) begin
            errors++;
            $display("FAIL reset_values valid=%b ready=%b vec=%h required 0,0,0", Out_Valid, In_Ready, dut_vec);
        end
        tick();
        Reset = 1'b0;
        checks++;
        if (In_Ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge got %b required 0", In_Ready); end
        tick();
        checks++;
        if (In_Ready !== exp_ready || exp_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_edge got %b required 1", In_Ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] instrs [4] = '{32'h00812283, 32'hFE512E23, 32'hFE208CE3, 32'h0000007F};
        logic [11:0] imms   [4] = '{12'h008, 12'hFFC, 12'hFFC, 12'h000};
        logic [2:0]  fmts   [4] = '{3'd1, 3'd2, 3'd3, 3'd7};
        Out_Ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            In_Valid = 1'b1; In_Instruction = instrs[k]; In_PC = 32'h1000 + 32'(4 * k);
            tick();
            checks++;
            if (Out_Valid !== 1'b1 || q_instr.size() != 1 || dut_vec !== exp_vec()) begin
                errors++; $display("FAIL directed_%0d valid=%b vec=%h", k, Out_Valid, dut_vec);
            end
            checks++;
            if (Out_Imm12 !== imms[k] || Out_Format !== fmts[k] || Out_Illegal !== (k == 3)) begin
                errors++;
                $display("FAIL directed_imm_%0d imm=%h fmt=%0d ill=%b required imm=%h fmt=%0d",
                         k, Out_Imm12, Out_Format, Out_Illegal, imms[k], fmts[k]);
            end
        end
        In_Valid = 1'b0;
        tick();
        checks++;
        if (Out_Valid !== 1'b0) begin errors++; $display("FAIL directed_drain valid=%b required 0", Out_Valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got[$];
        int          offered;
        offered = 0;
        Out_Ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            In_Valid = 1'b1; In_Instruction = 32'h00A00093 + 32'(c << 20); In_PC = 32'h2000 + 32'(4 * offered);
            if (exp_ready) offered++;
            tick();
        end
        checks++;
        if (In_Ready !== 1'b0 || offered != 2 || Out_PC !== 32'h2000) begin
            errors++; $display("FAIL b2b_full ready=%b pc=%h required 0,00002000", In_Ready, Out_PC);
        end
        Out_Ready = 1'b1;
        for (int c = 0; c < 12 && got.size() < 3; c++) begin
            if (Out_Valid) begin
                got.push_back(Out_PC);
                checks++;
                if (dut_vec !== exp_vec()) begin errors++; $display("FAIL b2b_fields vec=%h required %h", dut_vec, exp_vec()); end
            end
            if (In_Valid && exp_ready) begin
                In_Valid = 1'b0;
                if (offered < 3) begin
                    offered++; In_Valid = 1'b1; In_Instruction = 32'h00A00093 + 32'(2 << 20); In_PC = 32'h2008;
                end
            end else if (!In_Valid && offered < 3) begin
                offered++; In_Valid = 1'b1; In_Instruction = 32'h00A00093 + 32'(2 << 20); In_PC = 32'h2008;
            end
            tick();
        end
        In_Valid = 1'b0;
        checks++;
        if (got.size() != 3 || got[0] !== 32'h2000 || got[1] !== 32'h2004 || got[2] !== 32'h2008) begin
            errors++; $display("FAIL b2b_order count=%0d required 3 in order 2000,2004,2008", got.size());
        end
    endtask

    task automatic test_flush();
        fill_two(32'h3000);
        Flush = 1'b1; In_Valid = 1'b1; In_Instruction = 32'h00000033; In_PC = 32'h3FFC;
        tick();
        Flush = 1'b0; In_Valid = 1'b0;
        checks++;
        if (Out_Valid !== 1'b0 || In_Ready !== 1'b1) begin
            errors++; $display("FAIL flush_state valid=%b ready=%b required 0,1", Out_Valid, In_Ready);
        end
        Out_Ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (Out_Valid !== 1'b0) begin errors++; $display("FAIL flush_leak cycle %0d valid=%b required 0", c, Out_Valid); end
        end
    endtask

    task automatic test_reset_mid();
        fill_two(32'h4000);
        #2 Reset = 1'b1;
        q_instr.delete(); q_pc.delete(); exp_ready = 1'b0;
        #1;
        checks++;
        if (Out_Valid !== 1'b0 || In_Ready !== 1'b0) begin
            errors++; $display("FAIL reset_mid valid=%b ready=%b required 0,0", Out_Valid, In_Ready);
        end
        tick();
        Reset = 1'b0;
        Out_Ready = 1'b1;
        tick();
        checks++;
        if (Out_Valid !== 1'b0 || In_Ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_recover valid=%b ready=%b required 0,1", Out_Valid, In_Ready);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [7] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h33, 7'h7F};
        logic [31:0] pc_next;
        pc_next = 32'h8000;
        for (int c = 0; c < 400; c++) begin
            checks++;
            if (In_Ready !== exp_ready || Out_Valid !== (q_instr.size() > 0)) begin
                errors++;
                $display("FAIL rand_hs cycle %0d ready=%b valid=%b required %b,%b",
                         c, In_Ready, Out_Valid, exp_ready, q_instr.size() > 0);
            end
            if (q_instr.size() > 0) begin
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL rand_fields cycle %0d vec=%h required %h", c, dut_vec, exp_vec());
                end
            end
            if (!In_Valid || exp_ready || Flush) begin
                In_Valid = ($urandom_range(0, 3) != 0);
                In_Instruction = ($urandom() & 32'hFFFFFF80) | 32'(ops[$urandom_range(0, 6)]);
                In_PC = pc_next;
                pc_next += 4;
            end
            Out_Ready = ($urandom_range(0, 2) != 0);
            Flush = ($urandom_range(0, 24) == 0);
            tick();
        end
        Flush = 1'b0; In_Valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
